// File: rtl/mc_pkg.sv
// Shared constants and types for the multicycle MIPS control unit.
// Latency: n/a (declarations only).
// Backpressure: n/a.
// Contents: opcode/funct constants, alucont codes, aluop type, FSM state enum.
package mc_pkg;

  // Opcodes (instr[31:26])
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;

  // R-type funct codes (instr[5:0])
  localparam logic [5:0] FUNCT_ADD = 6'b100000;
  localparam logic [5:0] FUNCT_SUB = 6'b100010;
  localparam logic [5:0] FUNCT_AND = 6'b100100;
  localparam logic [5:0] FUNCT_OR  = 6'b100101;
  localparam logic [5:0] FUNCT_SLT = 6'b101010;

  // ALU control words consumed by the datapath ALU
  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_SLT = 3'b111;

  // What the FSM asks of the ALU in a given state
  typedef enum logic [1:0] {
    ALUOP_ADD   = 2'b00,
    ALUOP_SUB   = 2'b01,
    ALUOP_FUNCT = 2'b10
  } aluop_t;

  // Controller states; encodings 12..15 are unreachable and recover to FETCH
  typedef enum logic [3:0] {
    S_FETCH   = 4'd0,
    S_DECODE  = 4'd1,
    S_MEMADR  = 4'd2,
    S_MEMRD   = 4'd3,
    S_MEMWB   = 4'd4,
    S_MEMWR   = 4'd5,
    S_RTYPEEX = 4'd6,
    S_RTYPEWB = 4'd7,
    S_BEQEX   = 4'd8,
    S_ADDIEX  = 4'd9,
    S_ADDIWB  = 4'd10,
    S_JEX     = 4'd11
  } state_t;

endpackage

// File: rtl/mc_aludec.sv
// ALU decoder: maps (aluop, funct) to the 3-bit alucont word.
// Latency: purely combinational, zero cycles.
// Backpressure: none; output is valid whenever inputs are.
// Ports: aluop (from FSM output decode), funct (IR[5:0]) -> alucont (to ALU).
module mc_aludec
  import mc_pkg::*;
#(
  parameter int FUNCT_W = 6
) (
  input  aluop_t             aluop,
  input  logic [FUNCT_W-1:0] funct,
  output logic [2:0]         alucont
);

  always_comb begin
    alucont = ALU_ADD;
    case (aluop)
      ALUOP_ADD: alucont = ALU_ADD;
      ALUOP_SUB: alucont = ALU_SUB;
      ALUOP_FUNCT: begin
        case (funct)
          FUNCT_ADD: alucont = ALU_ADD;
          FUNCT_SUB: alucont = ALU_SUB;
          FUNCT_AND: alucont = ALU_AND;
          FUNCT_OR:  alucont = ALU_OR;
          FUNCT_SLT: alucont = ALU_SLT;
          // Unrecognised funct behaves as add; the writeback still happens.
          default:   alucont = ALU_ADD;
        endcase
      end
      default: alucont = ALU_ADD;
    endcase
  end

endmodule

// File: rtl/mc_controller.sv
// Multicycle MIPS control unit: sequences fetch/decode/execute/mem/writeback.
// Latency: Moore outputs one state per cycle; 2 (unknown op) to 5 (lw) cycles per instruction.
// Backpressure: none; IR is assumed stable from DECODE until the instruction ends.
// Ports: clk, reset_n (sync, active-low); op/funct from IR; zero from ALU;
//        pcen, iord, memwrite, irwrite, regdst, memtoreg, regwrite, alusrca,
//        alusrcb[1:0], pcsrc[1:0], alucont[2:0] to the datapath.
module mc_controller
  import mc_pkg::*;
#(
  parameter int OP_W    = 6,
  parameter int FUNCT_W = 6
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic [OP_W-1:0]    op,
  input  logic [FUNCT_W-1:0] funct,
  input  logic               zero,
  output logic               pcen,
  output logic               iord,
  output logic               memwrite,
  output logic               irwrite,
  output logic               regdst,
  output logic               memtoreg,
  output logic               regwrite,
  output logic               alusrca,
  output logic [1:0]         alusrcb,
  output logic [1:0]         pcsrc,
  output logic [2:0]         alucont
);

  state_t state_q, state_d;

  // Raw (ungated) state decode
  logic   pcwrite;
  logic   branch;
  logic   memwrite_raw;
  logic   irwrite_raw;
  logic   regwrite_raw;
  aluop_t aluop;

  // State register
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= S_FETCH;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = S_FETCH;
    case (state_q)
      S_FETCH: state_d = S_DECODE;
      S_DECODE: begin
        case (op)
          OP_LW:    state_d = S_MEMADR;
          OP_SW:    state_d = S_MEMADR;
          OP_RTYPE: state_d = S_RTYPEEX;
          OP_BEQ:   state_d = S_BEQEX;
          OP_ADDI:  state_d = S_ADDIEX;
          OP_J:     state_d = S_JEX;
          // Unknown opcodes retire as a nop with no writes
          default:  state_d = S_FETCH;
        endcase
      end
      S_MEMADR:  state_d = (op == OP_LW) ? S_MEMRD : S_MEMWR;
      S_MEMRD:   state_d = S_MEMWB;
      S_MEMWB:   state_d = S_FETCH;
      S_MEMWR:   state_d = S_FETCH;
      S_RTYPEEX: state_d = S_RTYPEWB;
      S_RTYPEWB: state_d = S_FETCH;
      S_BEQEX:   state_d = S_FETCH;
      S_ADDIEX:  state_d = S_ADDIWB;
      S_ADDIWB:  state_d = S_FETCH;
      S_JEX:     state_d = S_FETCH;
      default:   state_d = S_FETCH;
    endcase
  end

  // Output decode (Moore, from state_q only)
  always_comb begin
    pcwrite      = 1'b0;
    branch       = 1'b0;
    iord         = 1'b0;
    memwrite_raw = 1'b0;
    irwrite_raw  = 1'b0;
    regdst       = 1'b0;
    memtoreg     = 1'b0;
    regwrite_raw = 1'b0;
    alusrca      = 1'b0;
    alusrcb      = 2'b00;
    pcsrc        = 2'b00;
    aluop        = ALUOP_ADD;
    case (state_q)
      S_FETCH: begin
        irwrite_raw = 1'b1;
        alusrcb     = 2'b01;
        pcwrite     = 1'b1;
      end
      S_DECODE: begin
        // Branch target PC + (signimm<<2) lands in ALUOut ahead of BEQEX
        alusrcb = 2'b11;
      end
      S_MEMADR: begin
        alusrca = 1'b1;
        alusrcb = 2'b10;
      end
      S_MEMRD: begin
        iord = 1'b1;
      end
      S_MEMWB: begin
        memtoreg     = 1'b1;
        regwrite_raw = 1'b1;
      end
      S_MEMWR: begin
        iord         = 1'b1;
        memwrite_raw = 1'b1;
      end
      S_RTYPEEX: begin
        alusrca = 1'b1;
        aluop   = ALUOP_FUNCT;
      end
      S_RTYPEWB: begin
        regdst       = 1'b1;
        regwrite_raw = 1'b1;
      end
      S_BEQEX: begin
        alusrca = 1'b1;
        aluop   = ALUOP_SUB;
        pcsrc   = 2'b01;
        branch  = 1'b1;
      end
      S_ADDIEX: begin
        alusrca = 1'b1;
        alusrcb = 2'b10;
      end
      S_ADDIWB: begin
        regwrite_raw = 1'b1;
      end
      S_JEX: begin
        pcsrc   = 2'b10;
        pcwrite = 1'b1;
      end
      default: begin
      end
    endcase
  end

  // Architectural write strobes are held off while reset_n is low, so a
  // reset mid-instruction cannot commit any state.
  assign pcen     = reset_n & (pcwrite | (branch & zero));
  assign irwrite  = reset_n & irwrite_raw;
  assign memwrite = reset_n & memwrite_raw;
  assign regwrite = reset_n & regwrite_raw;

  mc_aludec #(
    .FUNCT_W (FUNCT_W)
  ) u_aludec (
    .aluop   (aluop),
    .funct   (funct),
    .alucont (alucont)
  );

endmodule

// File: tb/tb_mc_controller.sv
// Directed bench for mc_controller: expected output words are hand-written
// per state. Bit order of the packed word:
// {pcen,iord,memwrite,irwrite,regdst,memtoreg,regwrite,alusrca,alusrcb[1:0],pcsrc[1:0],alucont[2:0]}
module tb_mc_controller;

  logic       clk = 1'b0;
  logic       reset_n;
  logic [5:0] op;
  logic [5:0] funct;
  logic       zero;
  logic       pcen, iord, memwrite, irwrite, regdst, memtoreg, regwrite, alusrca;
  logic [1:0] alusrcb, pcsrc;
  logic [2:0] alucont;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mc_controller dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .op       (op),
    .funct    (funct),
    .zero     (zero),
    .pcen     (pcen),
    .iord     (iord),
    .memwrite (memwrite),
    .irwrite  (irwrite),
    .regdst   (regdst),
    .memtoreg (memtoreg),
    .regwrite (regwrite),
    .alusrca  (alusrca),
    .alusrcb  (alusrcb),
    .pcsrc    (pcsrc),
    .alucont  (alucont)
  );

  logic [14:0] obs;
  assign obs = {pcen, iord, memwrite, irwrite, regdst, memtoreg, regwrite, alusrca,
                alusrcb, pcsrc, alucont};

  // Hand-derived expected output words
  localparam logic [14:0] V_RESET   = 15'b0_0_0_0_0_0_0_0_01_00_010;
  localparam logic [14:0] V_FETCH   = 15'b1_0_0_1_0_0_0_0_01_00_010;
  localparam logic [14:0] V_DECODE  = 15'b0_0_0_0_0_0_0_0_11_00_010;
  localparam logic [14:0] V_MEMADR  = 15'b0_0_0_0_0_0_0_1_10_00_010;
  localparam logic [14:0] V_MEMRD   = 15'b0_1_0_0_0_0_0_0_00_00_010;
  localparam logic [14:0] V_MEMWB   = 15'b0_0_0_0_0_1_1_0_00_00_010;
  localparam logic [14:0] V_MEMWR   = 15'b0_1_1_0_0_0_0_0_00_00_010;
  localparam logic [14:0] V_RTYPEWB = 15'b0_0_0_0_1_0_1_0_00_00_010;
  localparam logic [14:0] V_BEQ_T   = 15'b1_0_0_0_0_0_0_1_00_01_110;
  localparam logic [14:0] V_BEQ_NT  = 15'b0_0_0_0_0_0_0_1_00_01_110;
  localparam logic [14:0] V_ADDIWB  = 15'b0_0_0_0_0_0_1_0_00_00_010;
  localparam logic [14:0] V_JEX     = 15'b1_0_0_0_0_0_0_0_00_10_010;

  // RTYPEEX word minus alucont; alucont is appended per funct
  localparam logic [11:0] V_RTYPEEX_HI = 12'b0_0_0_0_0_0_0_1_00_00;

  task automatic chk(input string tag, input logic [14:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, expv);
    end
  endtask

  // Advance one rising edge and settle before sampling
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  logic [5:0] funct_tab [6];
  logic [2:0] alu_tab   [6];

  initial begin
    funct_tab[0] = 6'b100000; alu_tab[0] = 3'b010;
    funct_tab[1] = 6'b100010; alu_tab[1] = 3'b110;
    funct_tab[2] = 6'b100100; alu_tab[2] = 3'b000;
    funct_tab[3] = 6'b100101; alu_tab[3] = 3'b001;
    funct_tab[4] = 6'b101010; alu_tab[4] = 3'b111;
    funct_tab[5] = 6'b000000; alu_tab[5] = 3'b010;

    reset_n = 1'b0;
    op      = 6'b000000;
    funct   = 6'b000000;
    zero    = 1'b0;

    // Reset held for three edges: write strobes stay low, decode is FETCH
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("reset_hold", V_RESET);
    end
    reset_n = 1'b1;
    #1;
    chk("reset_release_fetch", V_FETCH);

    // lw: FETCH DECODE MEMADR MEMRD MEMWB FETCH
    op = 6'b100011;
    tick(); chk("lw_decode", V_DECODE);
    tick(); chk("lw_memadr", V_MEMADR);
    tick(); chk("lw_memrd", V_MEMRD);
    tick(); chk("lw_memwb", V_MEMWB);
    tick(); chk("lw_fetch", V_FETCH);

    // R-type funct sweep including an unknown funct
    op = 6'b000000;
    for (int k = 0; k < 6; k++) begin
      funct = funct_tab[k];
      tick(); chk("r_decode", V_DECODE);
      tick(); chk("r_ex_alucont", {V_RTYPEEX_HI, alu_tab[k]});
      tick(); chk("r_wb", V_RTYPEWB);
      tick(); chk("r_fetch", V_FETCH);
    end
    funct = 6'b000000;

    // beq taken; zero held high through DECODE must not raise pcen there
    op   = 6'b000100;
    zero = 1'b1;
    tick(); chk("beq_t_decode_zero", V_DECODE);
    tick(); chk("beq_t_ex", V_BEQ_T);
    zero = 1'b0;
    #1;
    tick(); chk("beq_t_fetch", V_FETCH);

    // beq not taken
    tick(); chk("beq_nt_decode", V_DECODE);
    tick(); chk("beq_nt_ex", V_BEQ_NT);
    tick(); chk("beq_nt_fetch", V_FETCH);

    // beq with zero only during DECODE
    zero = 1'b1;
    tick(); chk("beq_dz_decode", V_DECODE);
    zero = 1'b0;
    #1;
    chk("beq_dz_decode_after", V_DECODE);
    tick(); chk("beq_dz_ex", V_BEQ_NT);
    tick(); chk("beq_dz_fetch", V_FETCH);

    // j: 3 cycles
    op = 6'b000010;
    tick(); chk("j_decode", V_DECODE);
    tick(); chk("j_ex", V_JEX);
    tick(); chk("j_fetch", V_FETCH);

    // addi
    op = 6'b001000;
    tick(); chk("addi_decode", V_DECODE);
    tick(); chk("addi_ex", V_MEMADR);
    tick(); chk("addi_wb", V_ADDIWB);
    tick(); chk("addi_fetch", V_FETCH);

    // Unknown op: DECODE then straight back to FETCH
    op = 6'b111111;
    tick(); chk("nop_decode", V_DECODE);
    tick(); chk("nop_fetch", V_FETCH);

    // Full sw
    op = 6'b101011;
    tick(); chk("sw_decode", V_DECODE);
    tick(); chk("sw_memadr", V_MEMADR);
    tick(); chk("sw_memwr", V_MEMWR);
    tick(); chk("sw_fetch", V_FETCH);

    // sw interrupted by reset in MEMADR: memwrite never seen, then FETCH
    tick(); chk("swr_decode", V_DECODE);
    tick(); chk("swr_memadr", V_MEMADR);
    reset_n = 1'b0;
    #1;
    chk("swr_reset_in_memadr", {V_MEMADR[14:13], 1'b0, V_MEMADR[11:0]});
    tick(); chk("swr_reset_edge", V_RESET);
    reset_n = 1'b1;
    #1;
    chk("swr_release_fetch", V_FETCH);
    tick(); chk("swr_after_decode", V_DECODE);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
